// File: rtl/hex_seg_pkg.sv
// hex_seg_pkg: shared constants for the 7-segment readback path.
// Holds the 16 active-low segment patterns (bit0 = a .. bit6 = g),
// the sticky error codes and the frame-collection state type.
package hex_seg_pkg;
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h18;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_PATTERN = 2'b01;
    localparam logic [1:0] ERR_SEQ     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic {WAIT_D0, COLLECT} state_t;
endpackage

// File: rtl/hex_segment_reader_seg7_to_nibble.sv
// seg7_to_nibble: decodes an active-low 7-segment pattern to its hex nibble.
// Ports: seg (7, in) pattern; nibble (4, out) decoded value; legal (1, out)
// high when seg is one of the 16 recognised glyphs.
module seg7_to_nibble
    import hex_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       legal
);
    always_comb begin
        nibble = 4'h0;
        legal  = 1'b1;
        case (seg)
            SEG_0: nibble = 4'h0;
            SEG_1: nibble = 4'h1;
            SEG_2: nibble = 4'h2;
            SEG_3: nibble = 4'h3;
            SEG_4: nibble = 4'h4;
            SEG_5: nibble = 4'h5;
            SEG_6: nibble = 4'h6;
            SEG_7: nibble = 4'h7;
            SEG_8: nibble = 4'h8;
            SEG_9: nibble = 4'h9;
            SEG_A: nibble = 4'hA;
            SEG_B: nibble = 4'hB;
            SEG_C: nibble = 4'hC;
            SEG_D: nibble = 4'hD;
            SEG_E: nibble = 4'hE;
            SEG_F: nibble = 4'hF;
            default: legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/hex_segment_reader.sv
// hex_segment_reader: reassembles a 16-bit word from four active-low
// 7-segment digits, checking pattern legality, digit order and idle timeout.
// Ports: clk; clear (sync active-high reset); seg_in[6:0]; digit_sel[1:0]
// (0 = least-significant nibble); seg_valid; err_ack; value[15:0] (last
// published word); value_valid (one-cycle publish pulse); busy (frame in
// progress); err_code[1:0] (sticky first error).
// Optional: define HEX_READER_CONFIRM_EN to publish a frame only when it
// repeats the previously completed frame.
module hex_segment_reader
    import hex_seg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [6:0]  seg_in,
    input  logic [1:0]  digit_sel,
    input  logic        seg_valid,
    input  logic        err_ack,
    output logic [15:0] value,
    output logic        value_valid,
    output logic        busy,
    output logic [1:0]  err_code
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state;
    logic [1:0]    expected;
    logic [TW-1:0] timer;
    logic [3:0]    n0, n1, n2;
    logic [3:0]    nibble;
    logic          legal;
    logic [1:0]    new_err;
    logic          take0, take_n, last, publish;
    logic [15:0]   word;

    seg7_to_nibble u_dec (.seg(seg_in), .nibble(nibble), .legal(legal));

    // A legal digit 0 always (re)starts a frame; in COLLECT it also flags
    // a sequence error through new_err.
    assign take0  = seg_valid && legal && digit_sel == 2'd0;
    assign take_n = state == COLLECT && seg_valid && legal && digit_sel == expected;
    assign last   = take_n && expected == 2'd3;
    assign word   = {nibble, n2, n1, n0};
    assign busy   = state == COLLECT;

    always_comb begin
        new_err = ERR_NONE;
        if (state == WAIT_D0) begin
            if (seg_valid && digit_sel == 2'd0 && !legal) new_err = ERR_PATTERN;
        end else if (seg_valid) begin
            if (!legal && (digit_sel == expected || digit_sel == 2'd0)) new_err = ERR_PATTERN;
            else if (digit_sel != expected) new_err = ERR_SEQ;
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            new_err = ERR_TIMEOUT;
        end
    end

`ifdef HEX_READER_CONFIRM_EN
    // Candidate is the last completed frame; any error forgets it.
    logic [15:0] cand;
    logic        cand_ok;
    assign publish = last && cand_ok && word == cand;
    always_ff @(posedge clk) begin
        if (clear) begin
            cand    <= '0;
            cand_ok <= 1'b0;
        end else if (last) begin
            cand    <= word;
            cand_ok <= 1'b1;
        end else if (new_err != ERR_NONE) begin
            cand_ok <= 1'b0;
        end
    end
`else
    assign publish = last;
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            state       <= WAIT_D0;
            expected    <= 2'd0;
            timer       <= '0;
            n0          <= '0;
            n1          <= '0;
            n2          <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            value_valid <= publish;
            value       <= publish ? word : value;
            // First error sticks; a new error in the ack cycle wins over the ack.
            err_code    <= (new_err != ERR_NONE && (err_code == ERR_NONE || err_ack)) ? new_err :
                           err_ack ? ERR_NONE : err_code;
            if (take0) begin
                n0       <= nibble;
                expected <= 2'd1;
                timer    <= '0;
                state    <= COLLECT;
            end else if (take_n) begin
                n1       <= expected == 2'd1 ? nibble : n1;
                n2       <= expected == 2'd2 ? nibble : n2;
                expected <= last ? 2'd0 : expected + 2'd1;
                timer    <= '0;
                state    <= last ? WAIT_D0 : COLLECT;
            end else if (new_err != ERR_NONE) begin
                expected <= 2'd0;
                timer    <= '0;
                state    <= WAIT_D0;
            end else if (state == COLLECT && !seg_valid) begin
                timer <= timer == TW'(TIMEOUT_CYCLES) ? timer : timer + TW'(1);
            end
        end
    end
endmodule

// File: tb/tb_hex_segment_reader.sv
// tb_hex_segment_reader: self-checking bench for hex_segment_reader with a
// publish scoreboard and a table of clean frames.
module tb_hex_segment_reader;
    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic [6:0]  seg_in = '0;
    logic [1:0]  digit_sel = '0;
    logic        seg_valid = 1'b0;
    logic        err_ack = 1'b0;
    logic [15:0] value;
    logic        value_valid;
    logic        busy;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    hex_segment_reader #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .clear(clear), .seg_in(seg_in), .digit_sel(digit_sel),
        .seg_valid(seg_valid), .err_ack(err_ack), .value(value),
        .value_valid(value_valid), .busy(busy), .err_code(err_code)
    );

    typedef struct {
        logic [15:0] word;
        int          due;
    } exp_t;

    typedef struct {
        logic [3:0][6:0] segs;
        logic [15:0]     word;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[5];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Publish monitor: every pulse must match the head of the scoreboard on its due cycle.
    always @(negedge clk) begin
        if (value_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_publish: got value %h, expected no publish (cycle %0d)", value, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("publish_value", value, mon_e.word);
                chk("publish_cycle", cyc, mon_e.due);
            end
        end else if (sb.size() > 0 && sb[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_publish: got none, expected %h at cycle %0d", sb[0].word, sb[0].due);
            mon_e = sb.pop_front();
        end
    end

    task automatic send(input logic [1:0] sel, input logic [6:0] seg);
        @(negedge clk);
        digit_sel = sel;
        seg_in    = seg;
        seg_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            seg_valid = 1'b0;
        end
    endtask

    task automatic ack();
        @(negedge clk);
        seg_valid = 1'b0;
        err_ack   = 1'b1;
        @(negedge clk);
        err_ack   = 1'b0;
    endtask

    task automatic push(input logic [15:0] w);
        exp_t e;
        e.word = w;
        e.due  = cyc + 1;
        sb.push_back(e);
    endtask

    initial begin
        vecs[0] = '{segs: {7'h79, 7'h08, 7'h30, 7'h0E}, word: 16'h1A3F};
        vecs[1] = '{segs: {7'h06, 7'h46, 7'h03, 7'h21}, word: 16'hECBD};
        vecs[2] = '{segs: {7'h02, 7'h12, 7'h19, 7'h24}, word: 16'h6542};
        vecs[3] = '{segs: {7'h21, 7'h46, 7'h03, 7'h08}, word: 16'hDCBA};
        vecs[4] = '{segs: {7'h46, 7'h21, 7'h06, 7'h0E}, word: 16'hCDEF};

        repeat (2) @(negedge clk);
        clear = 1'b0;
        chk("reset_value", value, 0);
        chk("reset_valid", value_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_err", err_code, 0);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 4; i++) begin
                send(2'(i), vecs[v].segs[i]);
                if (i == 1) chk("busy_mid_frame", busy, 1);
                if (i == 3) push(vecs[v].word);
            end
            idle(1);
            chk("frame_value", value, vecs[v].word);
            chk("frame_err", err_code, 0);
            chk("frame_busy", busy, 0);
        end

        send(0, 7'h40);
        send(1, 7'h40);
        send(3, 7'h40);
        idle(1);
        chk("seq_err", err_code, 2);
        chk("seq_busy", busy, 0);
        chk("seq_value_held", value, 16'hCDEF);
        for (int i = 0; i < 4; i++) begin
            send(2'(i), 7'h40);
            if (i == 3) push(16'h0000);
        end
        idle(1);
        chk("zero_frame_value", value, 0);
        chk("seq_err_sticky", err_code, 2);
        ack();
        chk("err_ack_clears", err_code, 0);

        send(0, 7'h0E);
        send(1, 7'h30);
        send(2, 7'h7F);
        idle(1);
        chk("pattern_err", err_code, 1);
        chk("pattern_busy", busy, 0);
        chk("pattern_value_held", value, 0);
        ack();

        send(0, 7'h0E);
        idle(1);
        idle(2);
        idle(1);
        chk("timeout_pre_err", err_code, 0);
        chk("timeout_pre_busy", busy, 1);
        idle(1);
        chk("timeout_err", err_code, 3);
        chk("timeout_busy", busy, 0);

        send(0, 7'h0E);
        send(0, 7'h40);
        send(1, 7'h79);
        send(2, 7'h24);
        send(3, 7'h30);
        push(16'h3210);
        idle(1);
        chk("restart_value", value, 16'h3210);
        chk("restart_keeps_first_err", err_code, 3);
        ack();

        send(0, 7'h40);
        send(2, 7'h40);
        idle(1);
        chk("seq_err_again", err_code, 2);
        send(0, 7'h40);
        @(negedge clk);
        digit_sel = 2'd1;
        seg_in    = 7'h7F;
        err_ack   = 1'b1;
        @(negedge clk);
        err_ack   = 1'b0;
        seg_valid = 1'b0;
        chk("new_err_beats_ack", err_code, 1);
        chk("new_err_busy", busy, 0);

        send(0, 7'h0E);
        send(1, 7'h30);
        send(2, 7'h08);
        @(negedge clk);
        seg_valid = 1'b0;
        clear     = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_value", value, 0);
        chk("clear_valid", value_valid, 0);
        chk("clear_busy", busy, 0);
        chk("clear_err", err_code, 0);
        for (int i = 0; i < 4; i++) begin
            send(2'(i), vecs[1].segs[i]);
            if (i == 3) push(16'hECBD);
        end
        idle(1);
        chk("post_clear_value", value, 16'hECBD);
        chk("post_clear_err", err_code, 0);

        idle(3);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
